// File: rtl/adc_stream_unpack_if.sv
// Byte-in / sample-out stream bundle for the ADC capture unpacker.
// slave = unpacker side, master = byte source / sample consumer side.
interface adc_stream_unpack_if;
  logic [7:0] byte_i;
  logic       byte_valid_i;
  logic       byte_ready_o;
  logic [9:0] sample_o;
  logic       sample_valid_o;
  logic       sample_ready_i;
  logic       sample_trig_o;

  modport slave (
    input  byte_i, byte_valid_i, sample_ready_i,
    output byte_ready_o, sample_o, sample_valid_o, sample_trig_o
  );

  modport master (
    output byte_i, byte_valid_i, sample_ready_i,
    input  byte_ready_o, sample_o, sample_valid_o, sample_trig_o
  );
endinterface

// File: rtl/adc_stream_unpack.sv
// Rebuilds 10-bit ADC samples + trigger mark from the MSB-first packed byte stream (3 samples/word).
// Sample valid the cycle after the 4th byte; bytes stall only while a full word waits. ADC_UNPACK_TAGCHECK_EN adds a sticky tag check.
module adc_stream_unpack #(
  parameter int unsigned COUNT_WIDTH = 32,
  parameter logic [1:0]  NO_TRIG_TAG = 2'b11
) (
  input  logic                   fifo_read_fifoclk,
  input  logic                   reset_i,
  input  logic                   clear_i,
  adc_stream_unpack_if.slave     bus,
  input  logic [COUNT_WIDTH-1:0] max_samples_i,
  output logic [COUNT_WIDTH-1:0] samples_o,
  output logic                   done_o,
  output logic                   tag_err_o
);

  logic [1:0]             byte_cnt_q, byte_cnt_d;
  logic [23:0]            shift_q, shift_d;
  logic [31:0]            word_q, word_d;
  logic                   word_full_q, word_full_d;
  logic [1:0]             idx_q, idx_d;
  logic                   trig_seen_q, trig_seen_d;
  logic                   trig_word_q, trig_word_d;
  logic [1:0]             trig_idx_q, trig_idx_d;
  logic [COUNT_WIDTH-1:0] samples_q, samples_d;
  logic                   done_q, done_d;

  logic        samp_hs, last_take, byte_rdy, byte_hs, word_load;
  logic [31:0] new_word;
  logic [1:0]  new_tag;

`ifdef ADC_UNPACK_TAGCHECK_EN
  logic tag_err_q, tag_err_d;
`endif

  always_comb begin
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    word_d      = word_q;
    word_full_d = word_full_q;
    idx_d       = idx_q;
    trig_seen_d = trig_seen_q;
    trig_word_d = trig_word_q;
    trig_idx_d  = trig_idx_q;
    samples_d   = samples_q;
    done_d      = done_q;
`ifdef ADC_UNPACK_TAGCHECK_EN
    tag_err_d   = tag_err_q;
`endif

    samp_hs   = word_full_q & ~done_q & bus.sample_ready_i;
    last_take = samp_hs & (idx_q == 2'd2);
    // The 4th byte may land only if the word register is free or is being emptied this cycle.
    byte_rdy  = ~done_q & ((byte_cnt_q != 2'd3) | ~word_full_q | last_take);
    byte_hs   = bus.byte_valid_i & byte_rdy;
    word_load = byte_hs & (byte_cnt_q == 2'd3);
    new_word  = {shift_q, bus.byte_i};
    new_tag   = new_word[31:30];

    if (byte_hs) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      shift_d    = {shift_q[15:0], bus.byte_i};
    end

    if (samp_hs) begin
      if (last_take) begin
        idx_d       = 2'd0;
        word_full_d = 1'b0;
      end else begin
        idx_d = idx_q + 2'd1;
      end
      if (samples_q != '1) begin
        samples_d = samples_q + COUNT_WIDTH'(1);
      end
      if ((max_samples_i != '0) && (samples_d == max_samples_i)) begin
        done_d = 1'b1;
      end
    end

    if (word_load) begin
      word_d      = new_word;
      word_full_d = 1'b1;
      idx_d       = 2'd0;
      if (!trig_seen_q && (new_tag != NO_TRIG_TAG)) begin
        trig_seen_d = 1'b1;
        trig_word_d = 1'b1;
        trig_idx_d  = new_tag;
      end else begin
        trig_word_d = 1'b0;
      end
`ifdef ADC_UNPACK_TAGCHECK_EN
      if (trig_seen_q && (new_tag != trig_idx_q)) begin
        tag_err_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge fifo_read_fifoclk) begin
    if (reset_i || clear_i) begin
      byte_cnt_q  <= 2'd0;
      shift_q     <= 24'd0;
      word_q      <= 32'd0;
      word_full_q <= 1'b0;
      idx_q       <= 2'd0;
      trig_seen_q <= 1'b0;
      trig_word_q <= 1'b0;
      trig_idx_q  <= 2'd0;
      samples_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      word_q      <= word_d;
      word_full_q <= word_full_d;
      idx_q       <= idx_d;
      trig_seen_q <= trig_seen_d;
      trig_word_q <= trig_word_d;
      trig_idx_q  <= trig_idx_d;
      samples_q   <= samples_d;
      done_q      <= done_d;
    end
  end

`ifdef ADC_UNPACK_TAGCHECK_EN
  always_ff @(posedge fifo_read_fifoclk) begin
    if (reset_i || clear_i) begin
      tag_err_q <= 1'b0;
    end else begin
      tag_err_q <= tag_err_d;
    end
  end
  assign tag_err_o = tag_err_q;
`else
  assign tag_err_o = 1'b0;
`endif

  always_comb begin
    case (idx_q)
      2'd0:    bus.sample_o = word_q[9:0];
      2'd1:    bus.sample_o = word_q[19:10];
      2'd2:    bus.sample_o = word_q[29:20];
      default: bus.sample_o = 10'd0;
    endcase
  end

  assign bus.byte_ready_o   = byte_rdy;
  assign bus.sample_valid_o = word_full_q & ~done_q;
  assign bus.sample_trig_o  = word_full_q & ~done_q & trig_word_q & (idx_q == trig_idx_q);
  assign samples_o          = samples_q;
  assign done_o             = done_q;

endmodule

// File: tb/tb_adc_stream_unpack.sv
// Bench for adc_stream_unpack: known-word table, hand sequences for latency/backpressure/limit/clear,
// and randomized word streams checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_adc_stream_unpack;
  localparam int CW = 32;

`ifdef ADC_UNPACK_TAGCHECK_EN
  localparam logic EXP_TAG_ERR = 1'b1;
`else
  localparam logic EXP_TAG_ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_i, clear_i;
  logic [CW-1:0] max_samples_i, samples_o;
  logic          done_o, tag_err_o;

  adc_stream_unpack_if bus();

  adc_stream_unpack #(.COUNT_WIDTH(CW), .NO_TRIG_TAG(2'b11)) dut (
    .fifo_read_fifoclk(clk),
    .reset_i(reset_i),
    .clear_i(clear_i),
    .bus(bus),
    .max_samples_i(max_samples_i),
    .samples_o(samples_o),
    .done_o(done_o),
    .tag_err_o(tag_err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [9:0] s; logic t; } samp_t;
  typedef struct { logic [31:0] word; logic [9:0] s0, s1, s2; logic [2:0] trig; } vec_t;

  samp_t       exp_q[$];
  logic [7:0]  byte_q[$];
  logic [31:0] words_q[$];
  int          n_cmp = 0, n_err = 0;
  int          exp_cnt;
  logic        exp_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic samp_t mk(input logic [9:0] s, input logic t);
    samp_t r;
    r.s = s;
    r.t = t;
    return r;
  endfunction

  task automatic push_word(input logic [31:0] w);
    byte_q.push_back(w[31:24]);
    byte_q.push_back(w[23:16]);
    byte_q.push_back(w[15:8]);
    byte_q.push_back(w[7:0]);
  endtask

  // Reference: plain arithmetic on each word, first non-3 tag marks the trigger, limit truncates.
  task automatic model_words(input int max);
    int unsigned u, tag;
    int          seen, emitted, total;
    seen = 0;
    emitted = 0;
    total = 3 * words_q.size();
    foreach (words_q[i]) begin
      u = words_q[i];
      push_word(words_q[i]);
      tag = u / 1073741824;
      for (int k = 0; k < 3; k++) begin
        int unsigned s;
        logic        t;
        s = (u / (1 << (10 * k))) % 1024;
        t = 1'b0;
        if (seen == 0 && tag != 3 && k == int'(tag)) t = 1'b1;
        if (max == 0 || emitted < max) begin
          exp_q.push_back(mk(10'(s), t));
          emitted++;
        end
      end
      if (tag != 3) seen = 1;
    end
    exp_cnt  = emitted;
    exp_done = (max != 0) && (total >= max);
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    clear_i = 1'b1;
    bus.byte_valid_i = 1'b0;
    bus.sample_ready_i = 1'b0;
    @(posedge clk); #1;
    clear_i = 1'b0;
    byte_q.delete();
    exp_q.delete();
    words_q.delete();
  endtask

  // Drives byte_q with random gaps and random ready; checks every taken sample and stall stability.
  task automatic run_stream(input int pv, input int pr);
    int         cyc;
    logic       stalled;
    logic [9:0] held_s;
    logic       held_t;
    samp_t      e;
    cyc = 0;
    stalled = 1'b0;
    held_s = '0;
    held_t = 1'b0;
    while (exp_q.size() != 0 && cyc < 4000) begin
      @(posedge clk); #1;
      if (byte_q.size() != 0 && $urandom_range(99) < pv) begin
        bus.byte_valid_i = 1'b1;
        bus.byte_i = byte_q[0];
      end else begin
        bus.byte_valid_i = 1'b0;
        bus.byte_i = 8'($urandom);
      end
      bus.sample_ready_i = ($urandom_range(99) < pr);
      @(negedge clk);
      if (stalled && bus.sample_valid_o) begin
        check("stall_sample_stable", 32'(bus.sample_o), 32'(held_s));
        check("stall_trig_stable", 32'(bus.sample_trig_o), 32'(held_t));
      end
      if (bus.byte_valid_i && bus.byte_ready_o) void'(byte_q.pop_front());
      if (bus.sample_valid_o && bus.sample_ready_i) begin
        e = exp_q.pop_front();
        check("sample", 32'(bus.sample_o), 32'(e.s));
        check("trig", 32'(bus.sample_trig_o), 32'(e.t));
        stalled = 1'b0;
      end else begin
        stalled = bus.sample_valid_o;
        held_s = bus.sample_o;
        held_t = bus.sample_trig_o;
      end
      cyc++;
    end
    check("timeout_samples_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // After the expected samples, no further sample may be offered.
  task automatic drain(input int cycles);
    int extra;
    extra = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      bus.sample_ready_i = 1'b1;
      bus.byte_valid_i = (byte_q.size() != 0);
      if (byte_q.size() != 0) bus.byte_i = byte_q[0];
      @(negedge clk);
      if (bus.sample_valid_o) extra++;
      if (bus.byte_valid_i && bus.byte_ready_o) void'(byte_q.pop_front());
    end
    check("extra_samples", 32'(extra), 32'd0);
    @(posedge clk); #1;
    bus.byte_valid_i = 1'b0;
    bus.sample_ready_i = 1'b0;
  endtask

  vec_t vecs[6];
  logic [7:0]  lat_b[4];
  logic [9:0]  lat_s[3];
  logic        lat_t[3];

  initial begin
    vecs[0] = '{word: 32'h7FF556AA, s0: 10'h2AA, s1: 10'h155, s2: 10'h3FF, trig: 3'b010};
    vecs[1] = '{word: 32'h00000000, s0: 10'h000, s1: 10'h000, s2: 10'h000, trig: 3'b001};
    vecs[2] = '{word: 32'hBFFFFFFF, s0: 10'h3FF, s1: 10'h3FF, s2: 10'h3FF, trig: 3'b100};
    vecs[3] = '{word: 32'hC0000000, s0: 10'h000, s1: 10'h000, s2: 10'h000, trig: 3'b000};
    vecs[4] = '{word: 32'h40300801, s0: 10'h001, s1: 10'h002, s2: 10'h003, trig: 3'b010};
    vecs[5] = '{word: 32'h12345678, s0: 10'h278, s1: 10'h115, s2: 10'h123, trig: 3'b001};
    lat_b = '{8'h7F, 8'hF5, 8'h56, 8'hAA};
    lat_s = '{10'h2AA, 10'h155, 10'h3FF};
    lat_t = '{1'b0, 1'b1, 1'b0};

    reset_i = 1'b1;
    clear_i = 1'b0;
    max_samples_i = '0;
    bus.byte_i = 8'h00;
    bus.byte_valid_i = 1'b0;
    bus.sample_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;
    @(negedge clk);
    check("rst_byte_ready", 32'(bus.byte_ready_o), 32'd1);
    check("rst_sample_valid", 32'(bus.sample_valid_o), 32'd0);
    check("rst_sample_trig", 32'(bus.sample_trig_o), 32'd0);
    check("rst_sample", 32'(bus.sample_o), 32'd0);
    check("rst_samples", samples_o, 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_tag_err", 32'(tag_err_o), 32'd0);

    // First-word latency and basic unpack, ready held high.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus.byte_valid_i = 1'b1;
      bus.byte_i = lat_b[i];
      bus.sample_ready_i = 1'b1;
      @(negedge clk);
      check("lat_byte_ready", 32'(bus.byte_ready_o), 32'd1);
      if (i == 3) check("lat_no_early_valid", 32'(bus.sample_valid_o), 32'd0);
    end
    @(posedge clk); #1;
    bus.byte_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("lat_valid", 32'(bus.sample_valid_o), 32'd1);
      check("lat_sample", 32'(bus.sample_o), 32'(lat_s[k]));
      check("lat_trig", 32'(bus.sample_trig_o), 32'(lat_t[k]));
      @(posedge clk); #1;
    end
    bus.sample_ready_i = 1'b0;
    @(negedge clk);
    check("lat_samples", samples_o, 32'd3);
    check("lat_valid_after", 32'(bus.sample_valid_o), 32'd0);

    // Table of single words, each after a clear.
    for (int v = 0; v < 6; v++) begin
      do_clear();
      push_word(vecs[v].word);
      exp_q.push_back(mk(vecs[v].s0, vecs[v].trig[0]));
      exp_q.push_back(mk(vecs[v].s1, vecs[v].trig[1]));
      exp_q.push_back(mk(vecs[v].s2, vecs[v].trig[2]));
      run_stream(100, 100);
      drain(4);
      check("vec_samples", samples_o, 32'd3);
      check("vec_done", 32'(done_o), 32'd0);
    end

    // Pre-trigger word, trigger word, then a later tagged word that must not re-trigger.
    do_clear();
    words_q = '{32'hC0000000, 32'h7FF556AA, 32'h7FF556AA};
    model_words(0);
    run_stream(70, 70);
    drain(4);
    check("pretrig_samples", samples_o, 32'(exp_cnt));

    // Backpressure: with ready low, the 4th byte of the second word must be refused.
    do_clear();
    push_word(32'h7FF556AA);
    push_word(32'h12345678);
    begin
      int acc;
      acc = 0;
      for (int c = 0; c < 12; c++) begin
        @(posedge clk); #1;
        bus.sample_ready_i = 1'b0;
        bus.byte_valid_i = (byte_q.size() != 0);
        if (byte_q.size() != 0) bus.byte_i = byte_q[0];
        @(negedge clk);
        if (bus.byte_valid_i && bus.byte_ready_o) begin
          void'(byte_q.pop_front());
          acc++;
        end
      end
      check("bp_bytes_accepted", 32'(acc), 32'd7);
      check("bp_byte_ready", 32'(bus.byte_ready_o), 32'd0);
      check("bp_held_sample", 32'(bus.sample_o), 32'h2AA);
    end
    exp_q = '{mk(10'h2AA, 1'b0), mk(10'h155, 1'b1), mk(10'h3FF, 1'b0),
              mk(10'h278, 1'b0), mk(10'h115, 1'b0), mk(10'h123, 1'b0)};
    run_stream(100, 50);
    drain(4);
    check("bp_samples", samples_o, 32'd6);

    // Sample limit of 4 across three words.
    do_clear();
    max_samples_i = 32'd4;
    words_q = '{32'h7FF556AA, 32'h12345678, 32'h40300801};
    model_words(4);
    run_stream(100, 100);
    drain(6);
    check("lim_done", 32'(done_o), 32'd1);
    check("lim_byte_ready", 32'(bus.byte_ready_o), 32'd0);
    check("lim_samples", samples_o, 32'd4);
    max_samples_i = 32'd0;
    @(negedge clk);
    check("lim_done_holds", 32'(done_o), 32'd1);

    // Clear in the middle of a byte sequence drops the partial word.
    do_clear();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      bus.byte_valid_i = 1'b1;
      bus.byte_i = lat_b[i];
    end
    do_clear();
    @(negedge clk);
    check("clr_samples_zero", samples_o, 32'd0);
    push_word(32'h7FF556AA);
    exp_q = '{mk(10'h2AA, 1'b0), mk(10'h155, 1'b1), mk(10'h3FF, 1'b0)};
    run_stream(100, 100);
    drain(4);
    check("clr_samples", samples_o, 32'd3);

    // Tag consistency: tag 1 then tag 2, then tag 1 again (error is sticky).
    do_clear();
    words_q = '{32'h40000000, 32'h80000000, 32'h40000000};
    model_words(0);
    run_stream(80, 80);
    drain(4);
    check("tag_err", 32'(tag_err_o), 32'(EXP_TAG_ERR));

    // Randomized streams against the reference model.
    for (int it = 0; it < 8; it++) begin
      int n, mx;
      do_clear();
      n = $urandom_range(8, 1);
      for (int w = 0; w < n; w++) begin
        logic [31:0] r;
        r = $urandom;
        r[31:30] = 2'($urandom_range(3, 0));
        words_q.push_back(r);
      end
      mx = ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(3 * n + 2, 1));
      max_samples_i = 32'(mx);
      model_words(mx);
      run_stream(int'($urandom_range(100, 30)), int'($urandom_range(100, 30)));
      drain(6);
      check("rnd_samples", samples_o, 32'(exp_cnt));
      check("rnd_done", 32'(done_o), 32'(exp_done));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adc_stream_unpack.md
Name: adc_stream_unpack

Overview:
- Receive side of the ADC capture byte stream: consumes the 8-bit stream produced by the capture FIFO read port and reconstructs 10-bit ADC samples plus the trigger position.
- Undoes the 3-samples-per-32-bit-word packing, including the 2-bit trigger tag, and emits one sample per handshake.
- Used on-chip for capture loopback/self-test and for replaying captured traces into downstream sample consumers.

Parameters:
- COUNT_WIDTH, 32, width of sample counter and max_samples_i.
- NO_TRIG_TAG, 2'b11, tag value meaning "trigger not yet seen in this word".

Ports:
- fifo_read_fifoclk  in  1  sole clock; all logic on its rising edge.
- reset_i  in  1  synchronous, active-high reset.
- clear_i  in  1  synchronous restart; same effect as reset_i on all state.
- byte_i  in  8  stream byte.
- byte_valid_i  in  1  byte_i valid.
- byte_ready_o  out  1  byte accepted when byte_valid_i & byte_ready_o.
- sample_o  out  10  reconstructed ADC sample.
- sample_valid_o  out  1  sample_o valid.
- sample_ready_i  in  1  downstream accepts sample when sample_valid_o & sample_ready_i.
- sample_trig_o  out  1  qualifies sample_o: this sample is the trigger sample.
- max_samples_i  in  COUNT_WIDTH  sample limit; 0 = unlimited.
- samples_o  out  COUNT_WIDTH  samples emitted since reset/clear.
- done_o  out  1  sample limit reached.
- tag_err_o  out  1  sticky tag-consistency error (optional feature only; else tied 0).

Behaviour:
- Word format: [31:30] tag, [29:20] s2, [19:10] s1, [9:0] s0.
- Byte order: MSB first; bytes arrive as [31:24], [23:16], [15:8], [7:0].
- Sample emission order per word: s0, s1, s2.
- Byte assembler:
  - 2-bit byte_cnt (0..3) and 24-bit shift register.
  - On the 4th accepted byte, the full 32-bit word loads into the word register: word_full=1, idx=0.
- byte_ready_o = ~done_o & ((byte_cnt != 3) | ~word_full | (sample handshake this cycle & idx==2)).
  - A new word can therefore load in the same cycle the last sample of the previous word is taken.
  - Zero-bubble throughput: 4 byte cycles per 3 samples.
- Latency: 4th byte accepted in cycle N -> sample_valid_o=1 with s0 in cycle N+1 (registered).
- Output stage:
  - sample_valid_o = word_full & ~done_o.
  - sample_o = s[idx], where idx is a 2-bit register that advances 0->1->2 on handshake.
  - On handshake at idx==2: word_full clears, unless a new word loads in the same cycle.
  - sample_o and sample_trig_o hold stable while valid & ~ready.
- Trigger tracking:
  - trig_seen register, cleared by reset/clear.
  - First loaded word with tag != NO_TRIG_TAG: record trig_idx=tag, mark the word "trigger word", set trig_seen.
  - sample_trig_o = 1 only while the trigger word is presented at idx==trig_idx. Exactly one pulse-sample per capture.
  - Tag values 0..2 are valid. A tag equal to NO_TRIG_TAG after trig_seen has no effect.
- Counting:
  - samples_o increments by 1 per sample handshake and saturates at all-ones.
  - If max_samples_i != 0 and the handshake makes samples_o == max_samples_i: done_o=1 next cycle.
  - With done_o=1: byte_ready_o=0, sample_valid_o=0, and the remaining samples of the current word are discarded.
  - done_o holds until reset_i/clear_i.
  - A max_samples_i change while running takes effect at the next comparison. No effect once done_o=1.
- Reset/clear, including mid-word or mid-byte-sequence:
  - byte_cnt=0, word_full=0, idx=0, trig_seen=0, samples_o=0, done_o=0, tag_err_o=0.
  - Partially assembled bytes are dropped.
  - Outputs in the cycle after reset: byte_ready_o=1, sample_valid_o=0, sample_trig_o=0, sample_o=0.
- reset_i and clear_i asserted together: identical to reset.

Optional Feature:
- Macro: ADC_UNPACK_TAGCHECK_EN.
- Defined: after trig_seen, every loaded word whose tag != trig_idx sets tag_err_o (sticky until reset/clear). A tag of NO_TRIG_TAG after trig_seen also counts as an error. The sample data path is unaffected.
- Not defined: no check logic is built; tag_err_o is constant 0.

Test Plan:
- Basic unpack:
  - Stimulus: bytes 7F F5 56 AA, sample_ready_i=1.
  - Response: samples 0x2AA, 0x155, 0x3FF; sample_trig_o=1 only on 0x155; samples_o=3.
- Pre-trigger words:
  - Stimulus: word 0xC0000000 (tag 3), then 0x7FF556AA.
  - Response: 6 samples; the only trig pulse is on the 5th sample (0x155); a following tag-1 word gives no further trig.
- Backpressure:
  - Stimulus: sample_ready_i toggled 1/0 while two words stream continuously.
  - Response: sample_o stable while stalled; byte_ready_o drops after the 4th byte of the second word until idx==2 is taken; no data loss or duplication.
- Limit:
  - Stimulus: max_samples_i=4, stream 3 words.
  - Response: exactly 4 samples emitted; done_o=1 the next cycle; byte_ready_o=0; samples_o=4.
- Mid-word clear:
  - Stimulus: clear_i after 2 bytes, then bytes 7F F5 56 AA.
  - Response: outputs 0x2AA, 0x155, 0x3FF with trig on 0x155; samples_o restarts from 0.
- Tag check (ADC_UNPACK_TAGCHECK_EN):
  - Stimulus: tag-1 word, then a tag-2 word.
  - Response: tag_err_o=1 and stays 1; without the macro, tag_err_o=0.
